// File: rtl/hazard_scheduler.sv
// RAW hazard stall / redirect flush sequencer for a 5-stage pipeline, with saturating perf counters.
// Outputs are combinational from ID inputs and scoreboard (0-cycle latency); enable=0 freezes all state and forces outputs low.
module hazard_scheduler #(
  parameter bit          WB_RF_BYPASS = 1'b0,
  parameter int unsigned FLUSH_CYCLES = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic [4:0]       id_waddr,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
  } sb_entry_t;

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES);

  sb_entry_t sb_ex, sb_mem, sb_wb, issue;
  state_t    state, state_next;
  logic [2:0] fc, fc_next;
  logic      rs_hit, rt_hit, hazard, kill;

  function automatic logic src_hit(input logic [4:0] src, input sb_entry_t e);
    return e.valid && (e.waddr == src);
  endfunction

  // $0 is hardwired, so it never matches; WB is skipped when the RF forwards same-cycle writes.
  always_comb begin
    rs_hit = id_uses_rs && (id_rs != 5'd0) &&
             (src_hit(id_rs, sb_ex) || src_hit(id_rs, sb_mem) ||
              (!WB_RF_BYPASS && src_hit(id_rs, sb_wb)));
    rt_hit = id_uses_rt && (id_rt != 5'd0) &&
             (src_hit(id_rt, sb_ex) || src_hit(id_rt, sb_mem) ||
              (!WB_RF_BYPASS && src_hit(id_rt, sb_wb)));
    hazard = id_valid && (rs_hit || rt_hit);
    kill   = ex_redirect || (state == FLUSH);
    flush  = enable && kill;
    stall  = enable && hazard && !kill;
    bubble = stall || flush;
    issue.valid = id_valid && id_reg_write && (id_waddr != 5'd0) && !stall && !flush;
    issue.waddr = id_waddr;
  end

  always_comb begin
    state_next = state;
    fc_next    = fc;
    case (state)
      IDLE: begin
        if (ex_redirect && (FLUSH_CYCLES != 0)) begin
          state_next = FLUSH;
          fc_next    = FC_LOAD;
        end
      end
      FLUSH: begin
        if (ex_redirect) begin
          fc_next = FC_LOAD;
        end else if (fc == 3'd1) begin
          state_next = IDLE;
          fc_next    = 3'd0;
        end else begin
          fc_next = fc - 3'd1;
        end
      end
      default: begin
        state_next = IDLE;
        fc_next    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sb_ex     <= '0;
      sb_mem    <= '0;
      sb_wb     <= '0;
      state     <= IDLE;
      fc        <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (enable) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= issue;
      state  <= state_next;
      fc     <= fc_next;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Drives three hazard_scheduler configurations with shared stimulus and checks each against hand-computed tables.
module tb_hazard_scheduler;

  logic clk = 1'b0;
  logic arst_n;
  logic enable, id_valid, id_uses_rs, id_uses_rt, id_reg_write, ex_redirect;
  logic [4:0] id_rs, id_rt, id_waddr;

  logic s0, b0, f0, s1, b1, f1, s2, b2, f2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.WB_RF_BYPASS(1'b0), .FLUSH_CYCLES(2), .CNT_W(16)) d0 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_waddr(id_waddr), .ex_redirect(ex_redirect),
    .stall(s0), .bubble(b0), .flush(f0), .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_scheduler #(.WB_RF_BYPASS(1'b1), .FLUSH_CYCLES(2), .CNT_W(16)) d1 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_waddr(id_waddr), .ex_redirect(ex_redirect),
    .stall(s1), .bubble(b1), .flush(f1), .stall_cnt(sc1), .flush_cnt(fc1));

  // Narrow counters here so saturation is reachable; FLUSH_CYCLES=0 means flush only in the redirect cycle.
  hazard_scheduler #(.WB_RF_BYPASS(1'b0), .FLUSH_CYCLES(0), .CNT_W(2)) d2 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_waddr(id_waddr), .ex_redirect(ex_redirect),
    .stall(s2), .bubble(b2), .flush(f2), .stall_cnt(sc2), .flush_cnt(fc2));

  typedef struct {
    logic en, v;
    logic [4:0] rs, rt;
    logic urs, urt, rw;
    logic [4:0] wa;
    logic rd;
    logic s0, f0, s1, f1, s2, f2;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(input logic en, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic rw, input logic [4:0] wa,
                              input logic rd, input logic e_s0, input logic e_f0, input logic e_s1,
                              input logic e_f1, input logic e_s2, input logic e_f2);
    vec_t r;
    r.en = en; r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.rw = rw; r.wa = wa; r.rd = rd;
    r.s0 = e_s0; r.f0 = e_f0; r.s1 = e_s1; r.f1 = e_f1; r.s2 = e_s2; r.f2 = e_f2;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw, input logic [4:0] wa, input logic rd);
    enable = en; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_waddr = wa; ex_redirect = rd;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
            vecs[i].rw, vecs[i].wa, vecs[i].rd);
      #1;
      chk($sformatf("v%0d stall0", i), s0, vecs[i].s0);
      chk($sformatf("v%0d flush0", i), f0, vecs[i].f0);
      chk($sformatf("v%0d bubble0", i), b0, vecs[i].s0 | vecs[i].f0);
      chk($sformatf("v%0d stall1", i), s1, vecs[i].s1);
      chk($sformatf("v%0d flush1", i), f1, vecs[i].f1);
      chk($sformatf("v%0d bubble1", i), b1, vecs[i].s1 | vecs[i].f1);
      chk($sformatf("v%0d stall2", i), s2, vecs[i].s2);
      chk($sformatf("v%0d flush2", i), f2, vecs[i].f2);
      chk($sformatf("v%0d bubble2", i), b2, vecs[i].s2 | vecs[i].f2);
    end
  endtask

  task automatic cnts(input string tag, input int es0, input int ef0, input int es1,
                      input int ef1, input int es2, input int ef2);
    chk({tag, " stall_cnt0"}, sc0, es0);
    chk({tag, " flush_cnt0"}, fc0, ef0);
    chk({tag, " stall_cnt1"}, sc1, es1);
    chk({tag, " flush_cnt1"}, fc1, ef1);
    chk({tag, " stall_cnt2"}, {30'd0, sc2}, es2);
    chk({tag, " flush_cnt2"}, {30'd0, fc2}, ef2);
  endtask

  initial begin
    //      en v  rs rt urs urt rw wa rd | s0 f0 s1 f1 s2 f2
    for (int i = 0; i < 5; i++)
      row(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // back-to-back producer $3 / consumer rs=3
    row(1, 1, 0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 3, 0, 1, 0, 1, 4, 0,  1, 0, 1, 0, 1, 0);
    row(1, 1, 3, 0, 1, 0, 1, 4, 0,  1, 0, 1, 0, 1, 0);
    row(1, 1, 3, 0, 1, 0, 1, 4, 0,  1, 0, 0, 0, 1, 0);
    row(1, 1, 3, 0, 1, 0, 1, 4, 0,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      row(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // $0 traffic, non-matching source, unused rt, then producer one instruction older
    row(1, 1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 0, 0, 1, 6, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 5, 6, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 5, 6, 1, 1, 0, 0, 0,  1, 0, 1, 0, 1, 0);
    row(1, 1, 5, 6, 1, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0);
    row(1, 1, 5, 6, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      row(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // redirect while a hazard is pending; killed ID writer $7 must not be recorded
    row(1, 1, 0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 3, 0, 1, 0, 1, 7, 1,  0, 1, 0, 1, 0, 1);
    row(1, 1, 3, 0, 1, 0, 1, 7, 0,  0, 1, 0, 1, 1, 0);
    row(1, 1, 3, 0, 1, 0, 1, 7, 0,  0, 1, 0, 1, 1, 0);
    row(1, 1, 7, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // second redirect one cycle into the flush window
    row(1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 0, 1);
    row(1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 0, 1);
    row(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
    row(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
    row(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // enable dropped for 4 cycles mid-stall
    row(1, 1, 0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 3, 0, 1, 0, 1, 4, 0,  1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      row(0, 1, 3, 0, 1, 0, 1, 4, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 3, 0, 1, 0, 1, 4, 0,  1, 0, 1, 0, 1, 0);
    row(1, 1, 3, 0, 1, 0, 1, 4, 0,  1, 0, 0, 0, 1, 0);
    row(1, 1, 3, 0, 1, 0, 1, 4, 0,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      row(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    arst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    cnts("reset", 0, 0, 0, 0, 0, 0);
    chk("reset stall0", s0, 0);
    chk("reset flush0", f0, 0);
    @(negedge clk);
    arst_n = 1'b1;

    run(0, 4);   cnts("idle",       0, 0, 0, 0, 0, 0);
    run(5, 12);  cnts("raw",        3, 0, 2, 0, 3, 0);
    run(13, 22); cnts("older",      5, 0, 3, 0, 3, 0);
    run(23, 27); cnts("redirect",   5, 3, 3, 3, 3, 1);
    run(28, 32); cnts("midflush",   5, 7, 3, 7, 3, 3);
    run(33, 38); cnts("frozen",     6, 7, 4, 7, 3, 3);
    run(39, 44); cnts("resume",     8, 7, 5, 7, 3, 3);

    // asynchronous reset in the middle of a stall
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 1, 3, 0);
    @(negedge clk);
    drive(1, 1, 3, 0, 1, 0, 1, 4, 0);
    #1;
    chk("pre-reset stall0", s0, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst stall0", s0, 0);
    chk("arst bubble0", b0, 0);
    chk("arst stall2", s2, 0);
    chk("arst stall_cnt0", sc0, 0);
    chk("arst flush_cnt0", fc0, 0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("post-reset stall0", s0, 0);

    // asynchronous reset in the middle of a flush window
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre-reset flush0", f0, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst flush0", f0, 0);
    chk("arst bubble0 flush", b0, 0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("post-reset flush0", f0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline sequencing controller for the 5-stage single-issue cpu datapath. It holds a 3-entry scoreboard of in-flight register writes (EX, MEM, WB) and detects read-after-write hazards for the instruction in ID. On a hazard it stalls fetch/decode and injects bubbles. On a taken branch or jump it flushes the wrong-path instructions. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- WB_RF_BYPASS, 0, 1 = register file forwards same-cycle write data to reads, so the WB entry never causes a hazard.
- FLUSH_CYCLES, 0, extra cycles (0–7) after a redirect during which the ID instruction is killed.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  main clock.
- arst_n  in  1  asynchronous active-low reset.
- enable  in  1  pipeline advance; all state is frozen when low.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  5  ID source register 1.
- id_rt  in  5  ID source register 2.
- id_uses_rs  in  1  ID reads rs.
- id_uses_rt  in  1  ID reads rt.
- id_reg_write  in  1  ID instruction writes the register file.
- id_waddr  in  5  ID destination, already selected by reg_dst.
- ex_redirect  in  1  the instruction in the scoreboard EX slot is a taken branch or jump.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero the ID/EX control signals.
- flush  out  1  clear IF/ID.
- stall_cnt  out  CNT_W  count of stalled cycles, saturating.
- flush_cnt  out  CNT_W  count of flush cycles, saturating.

## Operation
Scoreboard:
- Entries sb_ex, sb_mem, sb_wb. Each entry is {valid, waddr[4:0]}.
- On each enabled edge: sb_wb <= sb_mem; sb_mem <= sb_ex; sb_ex <= issue entry.
- The issue entry is valid only when all of the following hold: id_valid, id_reg_write, id_waddr != 0, stall=0, flush=0. Otherwise it is invalid (a bubble).

Hazard:
- For each used source s (s = id_rs or id_rt, with its id_uses_* set), s is a hazard when s != 0 and it matches the waddr of a valid entry.
- The entries checked are sb_ex and sb_mem, plus sb_wb when WB_RF_BYPASS=0.
- The hazard flag is the OR over both sources, qualified by id_valid.

Flush FSM:
- States: IDLE and FLUSH. A down-counter fc[2:0] runs in FLUSH.
- IDLE -> FLUSH on ex_redirect when FLUSH_CYCLES>0; fc is loaded with FLUSH_CYCLES.
- In FLUSH, fc decrements each enabled cycle. The FSM returns to IDLE when fc reaches 1 on an edge without a redirect.
- A redirect while in FLUSH reloads fc with FLUSH_CYCLES.

Outputs (combinational, all forced to 0 when enable=0):
- kill = ex_redirect | (state==FLUSH).
- flush = kill.
- stall = hazard & ~kill. A redirect has priority over a stall.
- bubble = stall | kill.

Counters:
- On an enabled edge, stall_cnt increments when stall=1, and flush_cnt increments when flush=1.
- Both counters saturate at all-ones.

## Timing
- Reset values: scoreboard entries invalid with waddr 0; state IDLE; fc=0; stall_cnt=0; flush_cnt=0. Hence stall=0, bubble=0, flush=0 after reset, once enable is applied with no inputs asserted.
- Reset is asynchronous and may assert mid-stall or mid-flush. It clears all state immediately, and the outputs drop in the same cycle.
- Decode-to-output latency is 0 cycles (combinational). The state is updated on the rising clk edge only when enable=1.
- Stall length for a producer-consumer pair issued back-to-back:
  - 3 cycles with WB_RF_BYPASS=0; 2 cycles with WB_RF_BYPASS=1.
  - If the producer is one instruction older, subtract 1 cycle; if two instructions older, subtract 2.
- Register $0 never creates a hazard, either as a source or as a destination.
- Redirect cycle: the ID instruction is not recorded in the scoreboard. The older entries shift normally and keep their state, because they are older than the branch.
- When enable is low, the scoreboard, FSM and counters all hold their values.

## Test plan
- Reset then enable with id_valid=0 for 5 cycles -> stall/bubble/flush stay 0; stall_cnt=0; flush_cnt=0.
- WB_RF_BYPASS=0: issue add $3 (id_waddr=3, reg_write=1), then next cycle ID = sub reading rs=3 -> stall=1 and bubble=1 for exactly 3 cycles, then 0; stall_cnt=3. Repeat with WB_RF_BYPASS=1 -> 2 cycles; stall_cnt=2.
- Producer writes $0, consumer reads $0 -> stall never asserts. A consumer reading $5 when only $6 is in flight -> no stall.
- FLUSH_CYCLES=2: pulse ex_redirect for 1 cycle while a hazard is pending -> flush=1 for 3 cycles, stall=0 throughout, flush_cnt=3. The ID instruction is not recorded: a following read of its waddr causes no stall.
- Mid-flush redirect: FLUSH_CYCLES=2, a second ex_redirect 1 cycle after the first -> flush stays high for 4 cycles in total, and flush_cnt=4.
- Drop enable for 4 cycles during a 3-cycle stall -> stall=0 while enable is low, state is frozen, and stall_cnt is unchanged. When enable returns, the remaining stall cycles complete, for a total stall_cnt of 3. Assert arst_n=0 during a stall -> outputs go to 0 asynchronously.
